// File: rtl/riscv_div_pkg.sv
// Shared constants and types for the divider issue stage and its checkers.
package riscv_div_pkg;

  localparam int unsigned XLEN               = 32;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 48;

  localparam logic [XLEN-1:0] DIV_MASK      = 32'hFE00_707F;
  localparam logic [XLEN-1:0] OP_DIV        = 32'h0200_4033;
  localparam logic [XLEN-1:0] OP_DIVU       = 32'h0200_5033;
  localparam logic [XLEN-1:0] OP_REM        = 32'h0200_6033;
  localparam logic [XLEN-1:0] OP_REMU       = 32'h0200_7033;
  localparam logic [XLEN-1:0] DIV_ZERO_QUOT = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_RESULT
  } state_e;

endpackage

// File: rtl/riscv_div_decode.sv
// Combinational classifier for the M-extension divide/remainder opcodes.
module riscv_div_decode
  import riscv_div_pkg::*;
(
  input  logic [XLEN-1:0] opcode_i,
  output logic            match_o,
  output logic            is_div_o,
  output logic            is_signed_o
);

  logic [XLEN-1:0] masked;

  // funct3 bit 1 separates quotient from remainder, bit 0 separates unsigned
  always_comb begin
    masked      = opcode_i & DIV_MASK;
    match_o     = (masked == OP_DIV) || (masked == OP_DIVU) ||
                  (masked == OP_REM) || (masked == OP_REMU);
    is_div_o    = match_o && !opcode_i[13];
    is_signed_o = match_o && !opcode_i[12];
  end

endmodule

// File: rtl/riscv_div_issue.sv
// Issue/writeback stage in front of the 32-bit divider, with completion watchdog.
// Optional feature: ZILLA_DIV_ZERO_BYPASS_EN answers divide-by-zero without the divider.
module riscv_div_issue
  import riscv_div_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic [XLEN-1:0] req_opcode_i,
  input  logic [XLEN-1:0] req_rs1_i,
  input  logic [XLEN-1:0] req_rs2_i,
  input  logic [4:0]      req_rd_i,
  output logic            div_valid_o,
  output logic [XLEN-1:0] div_opcode_o,
  output logic [XLEN-1:0] div_dividend_o,
  output logic [XLEN-1:0] div_divisor_o,
  input  logic            div_busy_i,
  input  logic            div_valid_i,
  input  logic [XLEN-1:0] div_result_i,
  output logic            wb_valid_o,
  input  logic            wb_ready_i,
  output logic [4:0]      wb_rd_o,
  output logic [XLEN-1:0] wb_value_o,
  output logic            busy_o,
  output logic            illegal_o,
  output logic            err_o
);

  localparam int unsigned    CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e            state_q, state_d;
  logic [XLEN-1:0]   op_q, op_d;
  logic [XLEN-1:0]   rs1_q, rs1_d;
  logic [XLEN-1:0]   rs2_q, rs2_d;
  logic [XLEN-1:0]   value_q, value_d;
  logic [4:0]        rd_q, rd_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              dec_match, dec_is_div, dec_is_signed;
  logic              ready_c, illegal_c, err_c;
  logic              unused_dec;

  riscv_div_decode u_decode (
    .opcode_i    (req_opcode_i),
    .match_o     (dec_match),
    .is_div_o    (dec_is_div),
    .is_signed_o (dec_is_signed)
  );

  // Signedness is the divider's concern; the decode flags are only partly consumed here
  assign unused_dec = dec_is_signed ^ dec_is_div;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      rd_q    <= '0;
      value_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      rd_q    <= rd_d;
      value_q <= value_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    rs1_d     = rs1_q;
    rs2_d     = rs2_q;
    rd_d      = rd_q;
    value_d   = value_q;
    cnt_d     = cnt_q;
    ready_c   = 1'b0;
    illegal_c = 1'b0;
    err_c     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        ready_c = !div_busy_i;
        if (req_valid_i && ready_c) begin
          if (dec_match) begin
            op_d    = req_opcode_i;
            rs1_d   = req_rs1_i;
            rs2_d   = req_rs2_i;
            rd_d    = req_rd_i;
            state_d = S_LAUNCH;
`ifdef ZILLA_DIV_ZERO_BYPASS_EN
            if (req_rs2_i == '0) begin
              value_d = dec_is_div ? DIV_ZERO_QUOT : req_rs1_i;
              state_d = S_RESULT;
            end
`endif
          end else begin
            illegal_c = 1'b1;
          end
        end
      end
      S_LAUNCH: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      // A completion arriving on the timeout cycle still counts as a result
      S_WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (div_valid_i) begin
          value_d = div_result_i;
          state_d = S_RESULT;
        end else if (cnt_q == CNT_LAST) begin
          err_c   = 1'b1;
          value_d = '0;
          state_d = S_RESULT;
        end
      end
      S_RESULT: begin
        if (wb_ready_i) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Handshake and pulse outputs are forced low while reset is held
  assign req_ready_o    = ready_c && !rst_i;
  assign illegal_o      = illegal_c && !rst_i;
  assign err_o          = err_c && !rst_i;
  assign div_valid_o    = (state_q == S_LAUNCH) && !rst_i;
  assign wb_valid_o     = (state_q == S_RESULT) && !rst_i;
  assign busy_o         = (state_q != S_IDLE) && !rst_i;
  assign div_opcode_o   = op_q;
  assign div_dividend_o = rs1_q;
  assign div_divisor_o  = rs2_q;
  assign wb_rd_o        = rd_q;
  assign wb_value_o     = value_q;

endmodule

// File: tb/tb_riscv_div_issue.sv
// Scoreboard bench for riscv_div_issue with a behavioural divider stand-in.
module tb_riscv_div_issue;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic [31:0] req_opcode_i = '0;
  logic [31:0] req_rs1_i = '0;
  logic [31:0] req_rs2_i = '0;
  logic [4:0]  req_rd_i = '0;
  logic        div_valid_o;
  logic [31:0] div_opcode_o, div_dividend_o, div_divisor_o;
  logic        div_busy_i = 1'b0;
  logic        div_valid_i = 1'b0;
  logic [31:0] div_result_i = '0;
  logic        wb_valid_o;
  logic        wb_ready_i = 1'b1;
  logic [4:0]  wb_rd_o;
  logic [31:0] wb_value_o;
  logic        busy_o, illegal_o, err_o;

  riscv_div_issue #(.TIMEOUT_CYCLES(48)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_opcode_i(req_opcode_i), .req_rs1_i(req_rs1_i), .req_rs2_i(req_rs2_i),
    .req_rd_i(req_rd_i),
    .div_valid_o(div_valid_o), .div_opcode_o(div_opcode_o),
    .div_dividend_o(div_dividend_o), .div_divisor_o(div_divisor_o),
    .div_busy_i(div_busy_i), .div_valid_i(div_valid_i), .div_result_i(div_result_i),
    .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i), .wb_rd_o(wb_rd_o),
    .wb_value_o(wb_value_o), .busy_o(busy_o), .illegal_o(illegal_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

`ifdef ZILLA_DIV_ZERO_BYPASS_EN
  localparam int ZLAT = 0;
  localparam int ZLAUNCH = 0;
`else
  localparam int ZLAT = 37;
  localparam int ZLAUNCH = 1;
`endif

  int          cyc = 0;
  int          n_vec = 0;
  int          n_err = 0;
  int          launches = 0;
  int          launch_cyc = 0;
  int          mode = 0;  // 0: divider answers after 36 cycles, 1: never answers, 2: bench drives divider
  logic [31:0] exp_op, exp_rs1, exp_rs2;
  logic [36:0] sb_q[$];
  logic [36:0] sb_e;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_div(input logic [31:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [2:0] f3;
    logic       ovf;
    f3  = op[14:12];
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    if (b == 32'd0) return f3[1] ? a : 32'hFFFF_FFFF;
    case (f3)
      3'b100:  return ovf ? a : 32'($signed(a) / $signed(b));
      3'b101:  return a / b;
      3'b110:  return ovf ? 32'd0 : 32'($signed(a) % $signed(b));
      default: return a % b;
    endcase
  endfunction

  // Divider stand-in: busy for the run, completion pulse 36 cycles after launch
  always begin : divider_model
    logic [31:0] res;
    logic        stable;
    int          n;
    @(negedge clk_i);
    if (!rst_i && mode != 2 && div_valid_o) begin
      launches++;
      launch_cyc = cyc;
      check("launch_opcode", div_opcode_o, exp_op);
      check("launch_dividend", div_dividend_o, exp_rs1);
      check("launch_divisor", div_divisor_o, exp_rs2);
      res    = ref_div(exp_op, exp_rs1, exp_rs2);
      stable = 1'b1;
      n      = (mode == 0) ? 36 : 60;
      for (int k = 1; k <= n; k++) begin
        @(posedge clk_i); #1;
        if (k == 1) div_busy_i = 1'b1;
        if (k == 36 && mode == 0) begin
          div_valid_i  = 1'b1;
          div_result_i = res;
        end
        @(negedge clk_i);
        stable &= (div_opcode_o == exp_op) && (div_dividend_o == exp_rs1) &&
                  (div_divisor_o == exp_rs2);
      end
      @(posedge clk_i); #1;
      div_valid_i  = 1'b0;
      div_busy_i   = 1'b0;
      div_result_i = '0;
      check("operands_held", 32'(stable), 32'd1);
    end
  end

  // Scoreboard monitor: every writeback handshake consumes one expectation
  always @(negedge clk_i) begin
    if (!rst_i && wb_valid_o && wb_ready_i) begin
      if (sb_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL wb_unexpected: got rd=%0d value=%h with nothing expected", wb_rd_o, wb_value_o);
      end else begin
        sb_e = sb_q.pop_front();
        check("wb_rd", 32'(wb_rd_o), 32'(sb_e[36:32]));
        check("wb_value", wb_value_o, sb_e[31:0]);
      end
    end
  end

  task automatic issue(input logic [31:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, output int c);
    int n = 0;
    @(negedge clk_i);
    while (!req_ready_o && n < 200) begin
      @(negedge clk_i);
      n++;
    end
    if (!req_ready_o) check("issue_ready_timeout", 32'd0, 32'd1);
    exp_op       = op;
    exp_rs1      = a;
    exp_rs2      = b;
    req_valid_i  = 1'b1;
    req_opcode_i = op;
    req_rs1_i    = a;
    req_rs2_i    = b;
    req_rd_i     = rd;
    @(posedge clk_i); #1;
    req_valid_i = 1'b0;
    c = cyc;
  endtask

  task automatic wait_wb(output int c);
    int n = 0;
    c = -1;
    while (n < 100) begin
      @(negedge clk_i);
      if (wb_valid_o) begin
        c = cyc;
        break;
      end
      n++;
    end
    if (c < 0) check("wb_valid_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    int n = 0;
    while ((sb_q.size() != 0 || busy_o || div_busy_i) && n < 200) begin
      @(negedge clk_i);
      n++;
    end
    check("drain_queue", 32'(sb_q.size()), 32'd0);
    check("drain_idle", 32'(busy_o || div_busy_i), 32'd0);
  endtask

  task automatic run_div(input string name, input logic [31:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd, input logic [31:0] v,
                         input int lat, input int nl);
    int ic, wc, l0;
    l0 = launches;
    sb_q.push_back({rd, v});
    issue(op, a, b, rd, ic);
    wait_wb(wc);
    check({name, "_wb_latency"}, 32'(wc - ic), 32'(lat));
    drain();
    check({name, "_launches"}, 32'(launches - l0), 32'(nl));
    if (nl != 0) check({name, "_launch_cycle"}, 32'(launch_cyc - ic), 32'd0);
  endtask

  initial begin : global_guard
    #500000;
    $display("FAIL global_timeout: got no finish expected finish within bound");
    $fatal(1);
  end

  initial begin : stimulus
    int ic, wc, ecyc, ill, l0, n, wbs;
    logic ok;

    // Reset state
    repeat (2) @(negedge clk_i);
    check("rst_req_ready", 32'(req_ready_o), 32'd0);
    check("rst_outputs", 32'({div_valid_o, wb_valid_o, busy_o, illegal_o, err_o}), 32'd0);
    @(posedge clk_i); #1 rst_i = 1'b0;
    @(negedge clk_i);
    check("post_rst_ready", 32'(req_ready_o), 32'd1);

    // Normal divides: DIV -7/2, signed overflow, REM of a negative dividend
    run_div("div_neg", 32'h0220_C2B3, 32'hFFFF_FFF9, 32'd2, 5'd5, 32'hFFFF_FFFD, 37, 1);
    run_div("div_ovf", 32'h0200_4633, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'h8000_0000, 37, 1);
    run_div("rem_neg", 32'h0200_66B3, 32'hFFFF_FFF9, 32'd2, 5'd13, 32'hFFFF_FFFF, 37, 1);

    // REMU 100/7 with writeback stalled for 10 cycles
    wb_ready_i = 1'b0;
    sb_q.push_back({5'd7, 32'd2});
    issue(32'h0220_F3B3, 32'd100, 32'd7, 5'd7, ic);
    wait_wb(wc);
    check("stall_wb_latency", 32'(wc - ic), 32'd37);
    ok = 1'b1;
    for (int k = 0; k < 10; k++) begin
      if (k > 0) @(negedge clk_i);
      ok &= wb_valid_o && (wb_value_o == 32'd2) && (wb_rd_o == 5'd7) && !req_ready_o && busy_o;
    end
    check("stall_hold", 32'(ok), 32'd1);
    @(posedge clk_i); #1 wb_ready_i = 1'b1;
    @(negedge clk_i);
    @(negedge clk_i);
    check("stall_release_idle", 32'({busy_o, wb_valid_o, req_ready_o}), 32'b001);
    drain();

    // Illegal opcode (ADD)
    l0  = launches;
    ill = 0;
    @(negedge clk_i);
    req_valid_i  = 1'b1;
    req_opcode_i = 32'h0000_0033;
    req_rs1_i    = 32'd1;
    req_rs2_i    = 32'd2;
    req_rd_i     = 5'd1;
    #1 if (illegal_o) ill++;
    @(posedge clk_i); #1 req_valid_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_i);
      if (illegal_o) ill++;
    end
    check("illegal_pulses", 32'(ill), 32'd1);
    check("illegal_stays_idle", 32'(busy_o), 32'd0);
    check("illegal_no_launch", 32'(launches - l0), 32'd0);

    // Watchdog: divider never answers
    mode = 1;
    sb_q.push_back({5'd9, 32'd0});
    issue(32'h0200_54B3, 32'd10, 32'd3, 5'd9, ic);
    n    = 0;
    ecyc = -1;
    while (n < 100) begin
      @(negedge clk_i);
      if (err_o) begin
        ecyc = cyc;
        break;
      end
      n++;
    end
    check("err_latency", 32'(ecyc - launch_cyc), 32'd48);
    @(negedge clk_i);
    check("err_single", 32'(err_o), 32'd0);
    drain();
    mode = 0;

    // Divide by zero
    run_div("div_zero", 32'h0200_41B3, 32'd5, 32'd0, 5'd3, 32'hFFFF_FFFF, ZLAT, ZLAUNCH);
    run_div("rem_zero", 32'h0200_6233, 32'd5, 32'd0, 5'd4, 32'd5, ZLAT, ZLAUNCH);

    // Reset during WAIT, then a stray completion pulse
    mode = 2;
    issue(32'h0200_55B3, 32'd20, 32'd4, 5'd11, ic);
    @(posedge clk_i); #1 div_busy_i = 1'b1;
    repeat (5) @(posedge clk_i);
    @(negedge clk_i);
    check("rst_mid_busy_before", 32'(busy_o), 32'd1);
    @(posedge clk_i); #1 rst_i = 1'b1;
    @(negedge clk_i);
    check("rst_mid_outputs", 32'({req_ready_o, wb_valid_o, busy_o, div_valid_o}), 32'd0);
    @(posedge clk_i); #1 rst_i = 1'b0;
    @(negedge clk_i);
    check("rst_mid_idle_blocked", 32'({busy_o, req_ready_o}), 32'd0);
    @(posedge clk_i); #1;
    div_valid_i  = 1'b1;
    div_result_i = 32'd5;
    @(posedge clk_i); #1;
    div_valid_i  = 1'b0;
    div_result_i = '0;
    wbs = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk_i);
      if (wb_valid_o || busy_o) wbs++;
    end
    check("rst_mid_stray_ignored", 32'(wbs), 32'd0);
    @(posedge clk_i); #1 div_busy_i = 1'b0;
    @(negedge clk_i);
    check("rst_mid_ready_after", 32'(req_ready_o), 32'd1);
    mode = 0;

    repeat (3) @(negedge clk_i);
    check("final_queue_empty", 32'(sb_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
